// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for a two-stage RV32 core: load-use stalls,
// control-transfer flushes, memory-wait holds, and cycle/retire counters.
module hazard_ctrl #(
  parameter logic [31:0] NOP = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_s1,
  input  logic [31:0] inst_s2,
  input  logic        br_taken,
  input  logic        mem_busy,
  input  logic        cnt_clr,
  output logic        pc_stall,
  output logic        s1_stall,
  output logic        s2_stall,
  output logic        s2_bubble,
  output logic        s1_flush,
  output logic        pc_redirect,
  output logic [31:0] cycle_cnt,
  output logic [31:0] inst_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FLUSH   = 2'd2,
    MEMWAIT = 2'd3
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  state_t     cur, nxt;
  logic       s1_valid, s2_valid;
  logic [6:0] op_s1, op_s2;
  logic [4:0] rs1_s1, rs2_s1, rd_s2;
  logic       use_rs1, use_rs2, load_use, redirect, retire;
  logic       unused_bits;

  assign op_s1       = inst_s1[6:0];
  assign rs1_s1      = inst_s1[19:15];
  assign rs2_s1      = inst_s1[24:20];
  assign op_s2       = inst_s2[6:0];
  assign rd_s2       = inst_s2[11:7];
  assign unused_bits = ^{inst_s1[31:25], inst_s1[14:12]};

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (op_s1)
      OP_R, OP_STORE, OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_I, OP_LOAD, OP_JALR, OP_SYS: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign load_use = (op_s2 == OP_LOAD) && (rd_s2 != 5'd0) &&
                    ((use_rs1 && (rs1_s1 == rd_s2)) || (use_rs2 && (rs2_s1 == rd_s2)));
  assign redirect = s2_valid && (br_taken || (op_s2 == OP_JAL) || (op_s2 == OP_JALR));

  // MEMWAIT with mem_busy released is evaluated exactly like RUN.
  always_comb begin
    pc_stall    = 1'b0;
    s1_stall    = 1'b0;
    s2_stall    = 1'b0;
    s2_bubble   = 1'b0;
    s1_flush    = 1'b0;
    pc_redirect = 1'b0;
    nxt         = RUN;
    if (rst) begin
      nxt = RUN;
    end else if (mem_busy) begin
      pc_stall = 1'b1;
      s1_stall = 1'b1;
      s2_stall = 1'b1;
      nxt      = MEMWAIT;
    end else begin
      case (cur)
        RUN, MEMWAIT: begin
          if (redirect) begin
            pc_redirect = 1'b1;
            s1_flush    = 1'b1;
            nxt         = FLUSH;
          end else if (load_use) begin
            pc_stall  = 1'b1;
            s1_stall  = 1'b1;
            s2_bubble = 1'b1;
            nxt       = LDSTALL;
          end
        end
        LDSTALL: begin
          if (redirect) begin
            pc_redirect = 1'b1;
            s1_flush    = 1'b1;
            nxt         = FLUSH;
          end
        end
        default: nxt = RUN;
      endcase
    end
  end

  assign retire = s2_valid && !s2_stall && (inst_s2 != NOP);
  assign state  = cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= RUN;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      cur      <= nxt;
      s1_valid <= 1'b1;
      if (!s2_stall)
        s2_valid <= s1_valid && !s1_flush && !s2_bubble;
      if (cnt_clr) begin
        cycle_cnt <= '0;
        inst_cnt  <= '0;
      end else begin
        cycle_cnt <= cycle_cnt + 32'd1;
        if (retire)
          inst_cnt <= inst_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_s1 = NOP, inst_s2 = NOP;
  logic        br_taken = 1'b0, mem_busy = 1'b0, cnt_clr = 1'b0;
  logic        pc_stall, s1_stall, s2_stall, s2_bubble, s1_flush, pc_redirect;
  logic [31:0] cycle_cnt, inst_cnt;
  logic [1:0]  state;

  always #5 clk = ~clk;

  hazard_ctrl #(.NOP(NOP)) dut (
    .clk(clk), .rst(rst), .inst_s1(inst_s1), .inst_s2(inst_s2),
    .br_taken(br_taken), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .pc_stall(pc_stall), .s1_stall(s1_stall), .s2_stall(s2_stall),
    .s2_bubble(s2_bubble), .s1_flush(s1_flush), .pc_redirect(pc_redirect),
    .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt), .state(state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Opcodes that read rs1 / rs2 as pipeline sources.
  logic [6:0] rs1_ops [7] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h73};
  logic [6:0] rs2_ops [3] = '{7'h33, 7'h23, 7'h63};

  function automatic bit m_load_use(input logic [31:0] a, input logic [31:0] b);
    logic [4:0] rd;
    rd = b[11:7];
    if (b[6:0] != 7'h03 || rd == 5'd0) return 1'b0;
    foreach (rs1_ops[i]) if (a[6:0] == rs1_ops[i] && a[19:15] == rd) return 1'b1;
    foreach (rs2_ops[i]) if (a[6:0] == rs2_ops[i] && a[24:20] == rd) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model state
  int          m_state = 0;
  bit          m_s1v = 1'b0, m_s2v = 1'b0;
  logic [31:0] m_cyc = '0, m_inst = '0;
  bit          m_en = 1'b0;

  initial begin : compare
    logic [5:0]  e_ctl;
    int          n_state;
    bit          n_s1v, n_s2v, redir, lu, stall_all;
    logic [31:0] n_cyc, n_inst;
    forever begin
      @(negedge clk);
      #3;
      redir = m_s2v && (br_taken || inst_s2[6:0] == 7'h6F || inst_s2[6:0] == 7'h67);
      lu    = m_load_use(inst_s1, inst_s2);
      e_ctl = '0;  // {pc_stall,s1_stall,s2_stall,s2_bubble,s1_flush,pc_redirect}
      n_state = 0;
      stall_all = 1'b0;
      if (rst) begin
        n_state = 0;
      end else if (mem_busy) begin
        e_ctl = 6'b111000; n_state = 3; stall_all = 1'b1;
      end else if (m_state != 2 && redir) begin
        e_ctl = 6'b000011; n_state = 2;
      end else if ((m_state == 0 || m_state == 3) && lu) begin
        e_ctl = 6'b110100; n_state = 1;
      end
      if (m_en) begin
        chk("ctl", {26'd0, pc_stall, s1_stall, s2_stall, s2_bubble, s1_flush, pc_redirect},
            {26'd0, e_ctl});
        chk("state", {30'd0, state}, m_state);
        chk("cycle_cnt", cycle_cnt, m_cyc);
        chk("inst_cnt", inst_cnt, m_inst);
      end
      if (rst) begin
        n_s1v = 0; n_s2v = 0; n_cyc = '0; n_inst = '0;
      end else begin
        n_s1v = 1;
        n_s2v = stall_all ? m_s2v : (m_s1v && !e_ctl[1] && !e_ctl[2]);
        if (cnt_clr) begin
          n_cyc = '0; n_inst = '0;
        end else begin
          n_cyc  = m_cyc + 1;
          n_inst = m_inst + ((m_s2v && !stall_all && inst_s2 != NOP) ? 1 : 0);
        end
      end
      @(posedge clk);
      m_state = n_state; m_s1v = n_s1v; m_s2v = n_s2v; m_cyc = n_cyc; m_inst = n_inst;
    end
  end

  function automatic logic [31:0] enc_r(input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] enc_ld(input int rd, input int rs1);
    return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'h03};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67,
                              7'h6F, 7'h37, 7'h17, 7'h73, 7'h0B};
    if ($urandom_range(0, 7) == 0) return NOP;
    w        = $urandom;
    w[6:0]   = ops[$urandom_range(0, 10)];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  task automatic drive(input logic [31:0] s1, input logic [31:0] s2,
                       input logic br, input logic busy, input logic clr, input logic rs);
    @(negedge clk);
    #1;
    inst_s1 = s1; inst_s2 = s2; br_taken = br; mem_busy = busy; cnt_clr = clr; rst = rs;
  endtask

  task automatic look();
    #3;
  endtask

  initial begin : stim
    logic [31:0] add_h, lw5, lw0, add0, lui5, jal1, add_n;
    logic [31:0] i0;
    add_h = enc_r(6, 5, 2);
    lw5   = enc_ld(5, 1);
    lw0   = enc_ld(0, 1);
    add0  = enc_r(6, 0, 2);
    lui5  = {20'd1, 5'd5, 7'h37};
    jal1  = {20'd0, 5'd1, 7'h6F};
    add_n = enc_r(1, 2, 3);

    @(posedge clk);
    m_en = 1'b1;

    // Reset asserted with hazard and branch present: controls stay low.
    drive(add_h, lw5, 1, 0, 0, 1); look();
    chk("rst_redirect", {31'd0, pc_redirect}, 32'd0);
    chk("rst_bubble", {31'd0, s2_bubble}, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_cycle", cycle_cnt, 32'd0);

    drive(NOP, NOP, 0, 0, 0, 0); look();
    drive(NOP, NOP, 0, 0, 0, 0); look();
    chk("cycle_after_rst", cycle_cnt, 32'd1);
    drive(NOP, NOP, 0, 0, 0, 0); look();

    // Load-use stall
    drive(add_h, lw5, 0, 0, 0, 0); look();
    chk("lu_stall", {26'd0, pc_stall, s1_stall, s2_stall, s2_bubble, s1_flush, pc_redirect},
        32'b110100);
    chk("lu_state", {30'd0, state}, 32'd0);
    drive(add_h, lw5, 0, 0, 0, 0); look();
    chk("ldstall_state", {30'd0, state}, 32'd1);
    chk("ldstall_suppress", {31'd0, pc_stall}, 32'd0);
    drive(NOP, NOP, 0, 0, 0, 0); look();
    chk("ldstall_exit", {30'd0, state}, 32'd0);

    drive(add0, lw0, 0, 0, 0, 0); look();
    chk("x0_no_stall", {31'd0, pc_stall}, 32'd0);
    drive(lui5, lw5, 0, 0, 0, 0); look();
    chk("lui_no_stall", {31'd0, pc_stall}, 32'd0);

    // JAL redirect
    drive(NOP, jal1, 0, 0, 0, 0); look();
    i0 = inst_cnt;
    chk("jal_redirect", {30'd0, pc_redirect, s1_flush}, 32'b11);
    drive(NOP, NOP, 0, 0, 0, 0); look();
    chk("flush_state", {30'd0, state}, 32'd2);
    drive(NOP, NOP, 0, 0, 0, 0); look();
    chk("flush_exit", {30'd0, state}, 32'd0);
    chk("jal_retire", inst_cnt, i0 + 32'd1);

    // Branch held behind mem_busy for 3 cycles
    for (int k = 0; k < 3; k++) begin
      drive(NOP, NOP, 1, 1, 0, 0); look();
      chk("busy_no_redirect", {31'd0, pc_redirect}, 32'd0);
      chk("busy_stalls", {29'd0, pc_stall, s1_stall, s2_stall}, 32'b111);
      chk("busy_state", {30'd0, state}, (k == 0) ? 32'd0 : 32'd3);
    end
    drive(NOP, NOP, 1, 0, 0, 0); look();
    chk("release_redirect", {31'd0, pc_redirect}, 32'd1);
    chk("release_state", {30'd0, state}, 32'd3);
    drive(NOP, NOP, 0, 0, 0, 0); look();
    drive(NOP, NOP, 0, 0, 0, 0); look();

    // Load-use and taken branch together: redirect wins
    drive(add_h, lw5, 1, 0, 0, 0); look();
    chk("lu_br_redirect", {31'd0, pc_redirect}, 32'd1);
    chk("lu_br_bubble", {31'd0, s2_bubble}, 32'd0);
    drive(NOP, NOP, 0, 0, 0, 0); look();
    drive(NOP, NOP, 0, 0, 0, 0); look();

    // Counter wrap via preload
    drive(NOP, add_n, 0, 0, 0, 0);
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    force dut.inst_cnt  = 32'hFFFF_FFFE;
    m_cyc  = 32'hFFFF_FFFE;
    m_inst = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_cnt;
    release dut.inst_cnt;
    #2;
    chk("preload_cycle", cycle_cnt, 32'hFFFF_FFFE);
    drive(NOP, add_n, 0, 0, 0, 0); look();
    chk("cycle_max", cycle_cnt, 32'hFFFF_FFFF);
    drive(NOP, add_n, 0, 0, 0, 0); look();
    chk("cycle_wrap", cycle_cnt, 32'd0);
    chk("inst_wrap", inst_cnt, 32'd0);
    drive(NOP, add_n, 0, 0, 1, 0); look();
    chk("pre_clr_inst", inst_cnt, 32'd1);
    drive(NOP, NOP, 0, 0, 0, 0); look();
    chk("clr_cycle", cycle_cnt, 32'd0);
    chk("clr_inst", inst_cnt, 32'd0);

    // Reset in the middle of a memory wait
    drive(NOP, NOP, 0, 1, 0, 0); look();
    drive(NOP, jal1, 1, 1, 0, 1); look();
    chk("rst_in_wait_ctl", {29'd0, pc_stall, s2_stall, pc_redirect}, 32'd0);
    drive(NOP, jal1, 1, 0, 0, 0); look();
    chk("rst_abort_state", {30'd0, state}, 32'd0);
    chk("rst_abort_redirect", {31'd0, pc_redirect}, 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      drive(rand_inst(), rand_inst(),
            1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 20),
            1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 1));
    end
    drive(NOP, NOP, 0, 0, 0, 0); look();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
